// File: rtl/wave_trig_capture_pkg.sv
// ----------------------------------------------------------------------------
// wave_trig_capture_pkg
// Shared definitions for the triggered waveform capture block: sample width,
// sample types, capture FSM state encoding, trigger edge-select constants and
// the signed edge-crossing helper.
// No ports (package).
// ----------------------------------------------------------------------------
package wave_trig_capture_pkg;

   localparam int SAMPLE_W = 12;

   // Native sample and a one-bit-wider type for threshold arithmetic, so that
   // level +/- hysteresis can never wrap.
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [SAMPLE_W:0]   wide_t;

   localparam logic EDGE_RISING  = 1'b0;
   localparam logic EDGE_FALLING = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WAIT_TRIG,
      ST_POST,
      ST_DONE
   } state_t;

   function automatic wide_t sext(input sample_t s);
      return {s[SAMPLE_W-1], s};
   endfunction

   // True when the step prev_s -> cur_s crosses level in the selected
   // direction. Rising: prev below, cur at/above. Falling: prev above,
   // cur at/below.
   function automatic logic is_crossing(input sample_t prev_s,
                                        input sample_t cur_s,
                                        input sample_t level,
                                        input logic    edge_sel);
      wide_t p;
      wide_t c;
      wide_t l;
      p = sext(prev_s);
      c = sext(cur_s);
      l = sext(level);
      if (edge_sel == EDGE_RISING) begin
         return (p < l) && (c >= l);
      end
      return (p > l) && (c <= l);
   endfunction

endpackage

// File: rtl/wave_trig_capture_if.sv
// ----------------------------------------------------------------------------
// wave_trig_capture_if
// Sample stream and buffer read bus of the capture block.
//   sample_in    : signed waveform sample
//   sample_valid : qualifies sample_in for one cycle
//   rd_addr      : logical read index, 0 = oldest captured sample
//   rd_data      : buffer read data, one cycle after rd_addr
// Modports: master = sample source / reader, slave = capture block.
// ----------------------------------------------------------------------------
interface wave_trig_capture_if #(
   parameter int DEPTH = 256
);
   import wave_trig_capture_pkg::*;

   sample_t                    sample_in;
   logic                       sample_valid;
   logic [$clog2(DEPTH)-1:0]   rd_addr;
   sample_t                    rd_data;

   modport master (
      output sample_in,
      output sample_valid,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  sample_in,
      input  sample_valid,
      input  rd_addr,
      output rd_data
   );

endinterface

// File: rtl/wave_trig_capture_ram.sv
// ----------------------------------------------------------------------------
// capture_ram
// Simple dual-port sample buffer: synchronous write port, registered read
// port with one cycle of latency.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset of the read register only
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data
// ----------------------------------------------------------------------------
module capture_ram
   import wave_trig_capture_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  sample_t                    wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output sample_t                    rd_data
);

   sample_t mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto block RAM; its
   // contents are only meaningful after a completed capture anyway.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/wave_trig_capture.sv
// ----------------------------------------------------------------------------
// wave_trig_capture
// Triggered waveform capture: after arm, keeps PRE pre-trigger samples,
// waits for a signed level crossing in the selected direction, then stores
// DEPTH-PRE-1 post-trigger samples and stops. The buffer is read by logical
// index with the trigger sample at index PRE.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : sample stream in, buffer read port (wave_trig_capture_if)
//   arm        : one-cycle pulse, accepted in IDLE or DONE
//   trig_level : signed trigger threshold
//   trig_edge  : 0 = rising, 1 = falling
//   busy       : high in FILL, WAIT_TRIG, POST
//   done       : high in DONE
// Build option: define TRIG_HYST_EN to require the signal to have gone at
// least HYST LSBs past the level on the opposite side before a crossing
// qualifies as a trigger.
// ----------------------------------------------------------------------------
module wave_trig_capture
   import wave_trig_capture_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int PRE   = 64,
   parameter int HYST  = 16
) (
   input  logic                clk,
   input  logic                rst,
   wave_trig_capture_if.slave  bus,
   input  logic                arm,
   input  sample_t             trig_level,
   input  logic                trig_edge,
   output logic                busy,
   output logic                done
);

   localparam int AW     = $clog2(DEPTH);
   localparam int POST_N = DEPTH - PRE - 1;

   localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
   localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
   localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
   localparam logic [AW-1:0] ONE       = AW'(1);

   state_t          state;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   start;
   logic [AW-1:0]   cnt;
   sample_t         prev;
   logic            prev_valid;

   logic            in_capture;
   logic            arm_accept;
   logic            wr_en;
   logic            crossing;
   logic            hyst_ok;
   logic            trig_hit;
   logic [AW-1:0]   rd_phys;

   assign in_capture = (state == ST_FILL) || (state == ST_WAIT_TRIG) ||
                       (state == ST_POST);
   assign arm_accept = arm && ((state == ST_IDLE) || (state == ST_DONE));
   assign wr_en      = !rst && bus.sample_valid && in_capture;

   assign crossing = prev_valid &&
                     is_crossing(prev, bus.sample_in, trig_level, trig_edge);
   assign trig_hit = (state == ST_WAIT_TRIG) && bus.sample_valid &&
                     crossing && hyst_ok;

`ifdef TRIG_HYST_EN
   wide_t thr_lo;
   wide_t thr_hi;
   wide_t cur_w;
   logic  hyst_armed;

   assign thr_lo = sext(trig_level) - wide_t'(HYST);
   assign thr_hi = sext(trig_level) + wide_t'(HYST);
   assign cur_w  = sext(bus.sample_in);

   // Qualification: set once the signal has been far enough on the
   // pre-crossing side; cleared by a new capture or by a consumed trigger.
   always_ff @(posedge clk) begin
      if (rst || arm_accept || trig_hit) begin
         hyst_armed <= 1'b0;
      end else if (in_capture && bus.sample_valid) begin
         if (trig_edge == EDGE_RISING) begin
            if (cur_w <= thr_lo) hyst_armed <= 1'b1;
         end else begin
            if (cur_w >= thr_hi) hyst_armed <= 1'b1;
         end
      end
   end

   assign hyst_ok = hyst_armed;
`else
   // Hysteresis disabled: every crossing qualifies.
   assign hyst_ok = (HYST >= 0);
`endif

   // Logical index 0 is the oldest sample of the capture window.
   assign rd_phys = start + bus.rd_addr;

   // NOTE: busy/done are assigned next to every state change so they come
   // straight from flops rather than from decoding the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         wr_ptr     <= '0;
         start      <= '0;
         cnt        <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ONE;
         end

         // prev tracks the last valid sample of the running capture; a new
         // capture forgets it so its first sample cannot trigger.
         if (arm_accept) begin
            prev_valid <= 1'b0;
         end else if (in_capture && bus.sample_valid) begin
            prev       <= bus.sample_in;
            prev_valid <= 1'b1;
         end

         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  state <= ST_FILL;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end

            ST_FILL: begin
               if (PRE == 0) begin
                  state <= ST_WAIT_TRIG;
               end else if (bus.sample_valid) begin
                  if (cnt == PRE_LAST) begin
                     state <= ST_WAIT_TRIG;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
            end

            ST_WAIT_TRIG: begin
               if (trig_hit) begin
                  // The trigger sample lands at wr_ptr this cycle.
                  start <= wr_ptr - PRE_OFS;
                  cnt   <= '0;
                  if (POST_N == 0) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_POST;
                  end
               end
            end

            ST_POST: begin
               if (bus.sample_valid) begin
                  if (cnt == POST_LAST) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   capture_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (bus.sample_in),
      .rd_addr (rd_phys),
      .rd_data (bus.rd_data)
   );

endmodule

// File: tb/tb_wave_trig_capture.sv
// ----------------------------------------------------------------------------
// tb_wave_trig_capture
// Directed bench for wave_trig_capture (DEPTH 256, PRE 64, level 100).
// Stimulus: sine source of amplitude 1288 and 256 samples per period, phase
// advancing once per valid cycle from 0 at each arm; or a 99/101 toggle.
// Buffer reads push their expected value into a queue; a monitor compares
// rd_data against the queue head one cycle after each read request.
// ----------------------------------------------------------------------------
module tb_wave_trig_capture;
   import wave_trig_capture_pkg::*;

   localparam int DEPTH = 256;
   localparam int PRE   = 64;
   localparam int HYST  = 16;
   localparam int AW    = $clog2(DEPTH);

   typedef struct {
      string name;
      int    expv;
   } exp_t;

   logic    clk = 1'b0;
   logic    rst;
   logic    arm;
   sample_t trig_level;
   logic    trig_edge;
   logic    busy;
   logic    done;

   wave_trig_capture_if #(.DEPTH(DEPTH)) bus ();

   wave_trig_capture #(
      .DEPTH (DEPTH),
      .PRE   (PRE),
      .HYST  (HYST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .arm        (arm),
      .trig_level (trig_level),
      .trig_edge  (trig_edge),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   sine_tab [DEPTH];
   exp_t sb_q [$];
   logic rd_req  = 1'b0;
   logic rd_pend = 1'b0;

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) rd_pend <= rd_req;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (sb_q.size() == 0) begin
            check("rd_unexpected", int'(bus.rd_data), -9999);
         end else begin
            check(sb_q[0].name, int'(bus.rd_data), sb_q[0].expv);
            void'(sb_q.pop_front());
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic int sine_val(input int p);
      real x;
      x = 1288.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 256.0);
      if (x >= 0.0) return int'($floor(x + 0.5));
      return -int'($floor(-x + 0.5));
   endfunction

   task automatic rd(input int addr, input string name, input int expv);
      exp_t e;
      e.name = name;
      e.expv = expv;
      sb_q.push_back(e);
      bus.rd_addr = AW'(addr);
      rd_req = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   // mode 0: sine, mode 1: 99/101 toggle. stride: one valid every stride
   // cycles. rst_at >= 0 pulses rst on that cycle and stops the run.
   task automatic run_capture(input logic edge_sel, input int mode,
                              input int stride, input int max_cyc,
                              input int rst_at, input bit extra_arms,
                              input string tag, output int cycles);
      int phase;
      phase = 0;
      cycles = -1;
      trig_edge = edge_sel;
      @(posedge clk);
      #1;
      arm = 1'b1;
      bus.sample_valid = 1'b0;
      @(posedge clk);
      #1;
      arm = 1'b0;
      check({tag, "_busy_after_arm"}, int'(busy), 1);
      check({tag, "_done_after_arm"}, int'(done), 0);
      for (int k = 0; k < max_cyc; k++) begin
         if ((k % stride) == stride - 1) begin
            bus.sample_valid = 1'b1;
            if (mode == 0) bus.sample_in = sample_t'(sine_tab[phase % DEPTH]);
            else           bus.sample_in = (phase % 2 == 0) ? 12'sd99 : 12'sd101;
            phase++;
         end else begin
            bus.sample_valid = 1'b0;
         end
         arm = extra_arms && (k == 100 || k == 300);
         if (k == rst_at) rst = 1'b1;
         @(posedge clk);
         #1;
         arm = 1'b0;
         rst = 1'b0;
         if (k == rst_at || done) begin
            cycles = k + 1;
            break;
         end
      end
      bus.sample_valid = 1'b0;
   endtask

   task automatic check_sine_capture(input string tag, input int trig_phase,
                                     input int v64, input int v63);
      rd(64, {tag, "_idx64"}, v64);
      rd(63, {tag, "_idx63"}, v63);
      for (int i = 0; i < DEPTH; i += 37) begin
         rd(i, $sformatf("%s_idx%0d", tag, i),
            sine_tab[(trig_phase - PRE + i) % DEPTH]);
      end
      rd(DEPTH - 1, {tag, "_idx255"},
         sine_tab[(trig_phase - PRE + DEPTH - 1) % DEPTH]);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      for (int p = 0; p < DEPTH; p++) sine_tab[p] = sine_val(p);

      rst = 1'b1;
      arm = 1'b0;
      trig_level = 12'sd100;
      trig_edge = EDGE_RISING;
      bus.sample_valid = 1'b0;
      bus.sample_in = '0;
      bus.rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_rd_data", int'(bus.rd_data), 0);

      // Rising, level 100: trigger on sample 260 (95 -> 126).
      run_capture(EDGE_RISING, 0, 1, 3000, -1, 1'b0, "rise", cyc);
      check("rise_cycles", cyc, 452);
      check("rise_done", int'(done), 1);
      check("rise_busy", int'(busy), 0);
      check_sine_capture("rise", 260, 126, 95);

      // Falling, level 100: trigger on sample 125 (126 -> 95).
      run_capture(EDGE_FALLING, 0, 1, 3000, -1, 1'b0, "fall", cyc);
      check("fall_cycles", cyc, 317);
      check_sine_capture("fall", 125, 95, 126);

      // 99/101 toggle around the level.
      run_capture(EDGE_RISING, 1, 1, 600, -1, 1'b0, "alt", cyc);
`ifdef TRIG_HYST_EN
      check("alt_hyst_busy", int'(busy), 1);
      check("alt_hyst_done", int'(done), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("alt_hyst_rst_busy", int'(busy), 0);
`else
      check("alt_cycles", cyc, 257);
      rd(64, "alt_idx64", 101);
      rd(63, "alt_idx63", 99);
      rd(0, "alt_idx0", 101);
      rd(255, "alt_idx255", 99);
`endif

      // Valid every other cycle: same data, twice the time.
      run_capture(EDGE_RISING, 0, 2, 3000, -1, 1'b0, "half", cyc);
      check("half_cycles", cyc, 904);
      check_sine_capture("half", 260, 126, 95);

      // Reset in POST, then a clean re-arm.
      run_capture(EDGE_RISING, 0, 1, 3000, 300, 1'b0, "rstpost", cyc);
      check("rstpost_busy", int'(busy), 0);
      check("rstpost_done", int'(done), 0);
      check("rstpost_rd_data", int'(bus.rd_data), 0);
      run_capture(EDGE_RISING, 0, 1, 3000, -1, 1'b0, "rearm", cyc);
      check("rearm_cycles", cyc, 452);
      check_sine_capture("rearm", 260, 126, 95);

      // Arm pulses in WAIT_TRIG and POST are ignored.
      run_capture(EDGE_RISING, 0, 1, 3000, -1, 1'b1, "xarm", cyc);
      check("xarm_cycles", cyc, 452);
      check_sine_capture("xarm", 260, 126, 95);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wave_trig_capture.md
WAVE_TRIG_CAPTURE -- requirements
Module: wave_trig_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 256 (power of two), capture buffer depth in samples.
REQ-002 SHALL have parameter PRE, default 64, pre-trigger samples kept; 0 <= PRE < DEPTH.
REQ-003 SHALL have parameter HYST, default 16, trigger hysteresis in LSBs (used only with TRIG_HYST_EN).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_in  in  12 signed  waveform sample from generator/ADC path.
REQ-007 SHALL have port sample_valid  in  1  qualifies sample_in for one cycle.
REQ-008 SHALL have port arm  in  1  single-cycle pulse that starts a capture.
REQ-009 SHALL have port trig_level  in  12 signed  trigger threshold.
REQ-010 SHALL have port trig_edge  in  1  0 = rising, 1 = falling.
REQ-011 SHALL have port rd_addr  in  log2(DEPTH)  logical read index, 0 = oldest captured sample.
REQ-012 SHALL have port rd_data  out  12 signed  buffer read data.
REQ-013 SHALL have port busy  out  1  high in FILL, WAIT_TRIG, POST.
REQ-014 SHALL have port done  out  1  high in DONE.

Function
REQ-015 SHALL implement FSM IDLE -> FILL -> WAIT_TRIG -> POST -> DONE; arm in IDLE or DONE enters FILL; arm in any other state ignored.
REQ-016 Each valid sample in FILL/WAIT_TRIG/POST SHALL be written at wr_ptr, wr_ptr incremented modulo DEPTH; invalid cycles write nothing.
REQ-017 FILL SHALL count PRE valid samples then go to WAIT_TRIG (PRE = 0: straight to WAIT_TRIG on next cycle).
REQ-018 Rising trigger SHALL be prev < trig_level and cur >= trig_level; falling SHALL be prev > trig_level and cur <= trig_level; prev = previous valid sample.
REQ-019 prev SHALL be invalidated on arm; first valid sample after arm SHALL never trigger.
REQ-020 Trigger sample SHALL be written and its address latched; start = trigger address - PRE modulo DEPTH.
REQ-021 POST SHALL store DEPTH-PRE-1 further valid samples then go to DONE; trigger sample sits at logical index PRE.
REQ-022 Crossings in FILL SHALL be ignored; write pointer continues wrapping in WAIT_TRIG indefinitely.
REQ-023 rd_data SHALL equal mem[(start + rd_addr) mod DEPTH], registered, 1-cycle latency; content defined only in DONE.
REQ-024 Comparisons SHALL be signed; threshold arithmetic SHALL use 13-bit signed to avoid overflow.
REQ-025 arm and trigger on the same cycle in DONE: arm wins, restart in FILL.

Reset
REQ-026 rst SHALL force IDLE, busy = 0, done = 0, wr_ptr = 0, start = 0, prev invalid, rd_data = 0 on the next edge, including mid-capture.
REQ-027 Buffer memory SHALL NOT require reset.

Configuration
REQ-028 With TRIG_HYST_EN defined, rising trigger SHALL additionally require the signal to have been <= trig_level - HYST since arm or last disqualification (falling: >= trig_level + HYST); without it, REQ-018 alone applies and HYST is unused.

Structure
REQ-029 Shared package SHALL hold state encoding, sample width (12) and edge-select constants.
REQ-030 Buffer SHALL be one sub-module capture_ram (simple dual-port, sync write, registered read).

Verification (DEPTH 256, PRE 64, samples = sine generator with phase +1 per valid cycle)
REQ-031 Rising, level 100: arm, feed full cycles -> done; rd_addr 64 -> 126, rd_addr 63 -> 95.
REQ-032 Falling, level 100 -> rd_addr 64 -> 95, rd_addr 63 -> 126.
REQ-033 Samples alternating 99/101, level 100 rising -> triggers without TRIG_HYST_EN; busy stays high, no done with it.
REQ-034 sample_valid low every other cycle -> identical captured data as REQ-031; done after 2x cycles.
REQ-035 rst pulse during POST -> next cycle busy 0, done 0; re-arm gives REQ-031 result.
REQ-036 arm pulses during WAIT_TRIG and POST -> ignored; single capture, REQ-031 result.
